// File: rtl/vga_bbox_if.sv
// VGA video bundle: colours plus the four sync/blank controls travelling with each pixel.
// The master modport drives the stream and the slave modport receives it.
interface vga_bbox_if;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       sync_n;
    logic       blank_n;

    modport master (output r, g, b, hs, vs, sync_n, blank_n);
    modport slave  (input  r, g, b, hs, vs, sync_n, blank_n);
endinterface

// File: rtl/vga_bbox_overlay.sv
// Per-frame bright-pixel counter and bounding-box tracker.
// It draws the previous frame's box on the video, which passes through with one cycle of latency.
module vga_bbox_overlay #(
    parameter int          WIDTH   = 640,
    parameter int          HEIGHT  = 480,
    parameter int          CNT_W   = 20,
    parameter logic [23:0] BOX_RGB = 24'hFF0000
) (
    input  logic              VGA_CLK,
    input  logic              reset_n,
    vga_bbox_if.slave         i_vga,
    vga_bbox_if.master        o_vga,
    input  logic [7:0]        threshold,
    input  logic              overlay_en,
    output logic [CNT_W-1:0]  hit_count,
    output logic [9:0]        bbox_x0,
    output logic [9:0]        bbox_x1,
    output logic [9:0]        bbox_y0,
    output logic [9:0]        bbox_y1,
    output logic              bbox_empty,
    output logic              stats_valid,
    output logic              frame_err,
    output logic              frame_done
);
    localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
    localparam logic [9:0] Y_END  = 10'(HEIGHT);

    typedef enum logic {S_SYNC_WAIT, S_RUN} state_t;
    state_t r_state, w_state_nxt;

    logic [9:0]       r_x, r_y;
    logic [7:0]       r_thr;
    logic             r_ovl_en;
    logic [CNT_W-1:0] r_acc_cnt;
    logic [9:0]       r_acc_x0, r_acc_x1, r_acc_y0, r_acc_y1;
    logic             r_acc_empty, r_acc_err;
    logic [CNT_W-1:0] r_hit_count;
    logic [9:0]       r_bx0, r_bx1, r_by0, r_by1;
    logic             r_bbox_empty, r_stats_valid, r_frame_err, r_frame_done;
    logic [23:0]      r_o_rgb;
    logic             r_o_hs, r_o_vs, r_o_sync_n, r_o_blank_n;

    logic [7:0]  w_max_rg, w_max;
    logic        w_vs_fall, w_latch, w_active, w_in_frame, w_hit;
    logic        w_perim, w_ovl, w_final_bad;
    logic [23:0] w_out_rgb;

    // The registered vsync output doubles as the previous-vsync sample.
    assign w_vs_fall   = r_o_vs & ~i_vga.vs;
    assign w_latch     = w_vs_fall & (r_state == S_RUN);
    assign w_active    = i_vga.blank_n;
    assign w_in_frame  = (r_y < Y_END);
    assign w_max_rg    = (i_vga.r > i_vga.g) ? i_vga.r : i_vga.g;
    assign w_max       = (w_max_rg > i_vga.b) ? w_max_rg : i_vga.b;
    assign w_hit       = (r_state == S_RUN) & w_active & w_in_frame & (w_max >= r_thr);
    assign w_final_bad = (r_x != 10'd0) | (r_y != Y_END);

    assign w_perim = (((r_x == r_bx0) || (r_x == r_bx1)) && (r_y >= r_by0) && (r_y <= r_by1)) ||
                     (((r_y == r_by0) || (r_y == r_by1)) && (r_x >= r_bx0) && (r_x <= r_bx1));
    assign w_ovl   = r_ovl_en & ~r_bbox_empty & w_active & w_perim;
    assign w_out_rgb = !w_active ? 24'h0 :
                       w_ovl     ? BOX_RGB : {i_vga.r, i_vga.g, i_vga.b};

    always_comb begin
        w_state_nxt = r_state;
        if (w_vs_fall) w_state_nxt = S_RUN;
    end

    always_ff @(posedge VGA_CLK) begin
        if (!reset_n) r_state <= S_SYNC_WAIT;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge VGA_CLK) begin
        if (!reset_n) begin
            r_x <= '0; r_y <= '0;
            r_thr <= '0; r_ovl_en <= 1'b0;
            r_acc_cnt <= '0;
            r_acc_x0 <= '1; r_acc_y0 <= '1; r_acc_x1 <= '0; r_acc_y1 <= '0;
            r_acc_empty <= 1'b1; r_acc_err <= 1'b0;
            r_hit_count <= '0;
            r_bx0 <= '0; r_bx1 <= '0; r_by0 <= '0; r_by1 <= '0;
            r_bbox_empty <= 1'b1; r_stats_valid <= 1'b0;
            r_frame_err <= 1'b0; r_frame_done <= 1'b0;
            r_o_rgb <= '0; r_o_hs <= 1'b1; r_o_vs <= 1'b1;
            r_o_sync_n <= 1'b0; r_o_blank_n <= 1'b0;
        end else begin
            r_thr        <= threshold;
            r_ovl_en     <= overlay_en;
            r_o_rgb      <= w_out_rgb;
            r_o_hs       <= i_vga.hs;
            r_o_vs       <= i_vga.vs;
            r_o_sync_n   <= i_vga.sync_n;
            r_o_blank_n  <= i_vga.blank_n;
            r_frame_done <= w_latch;

            if (!i_vga.vs) begin
                r_x <= '0; r_y <= '0;
            end else if (w_active) begin
                if (r_x == X_LAST) begin
                    r_x <= '0;
                    if (r_y != 10'h3FF) r_y <= r_y + 10'd1;
                end else begin
                    r_x <= r_x + 10'd1;
                end
            end

            if (w_latch) begin
                r_hit_count   <= r_acc_cnt;
                r_bx0         <= r_acc_empty ? 10'd0 : r_acc_x0;
                r_bx1         <= r_acc_empty ? 10'd0 : r_acc_x1;
                r_by0         <= r_acc_empty ? 10'd0 : r_acc_y0;
                r_by1         <= r_acc_empty ? 10'd0 : r_acc_y1;
                r_bbox_empty  <= r_acc_empty;
                r_frame_err   <= r_acc_err | w_final_bad;
                r_stats_valid <= 1'b1;
            end

            // Any boundary, including the first one after sync-up, starts a clean accumulation.
            if (w_vs_fall) begin
                r_acc_cnt <= '0;
                r_acc_x0 <= '1; r_acc_y0 <= '1; r_acc_x1 <= '0; r_acc_y1 <= '0;
                r_acc_empty <= 1'b1; r_acc_err <= 1'b0;
            end else if (r_state == S_RUN && w_active) begin
                if (!w_in_frame) begin
                    r_acc_err <= 1'b1;
                end else if (w_hit) begin
                    if (r_acc_cnt != '1) r_acc_cnt <= r_acc_cnt + 1'b1;
                    if (r_x < r_acc_x0) r_acc_x0 <= r_x;
                    if (r_x > r_acc_x1) r_acc_x1 <= r_x;
                    if (r_y < r_acc_y0) r_acc_y0 <= r_y;
                    if (r_y > r_acc_y1) r_acc_y1 <= r_y;
                    r_acc_empty <= 1'b0;
                end
            end
        end
    end

    assign o_vga.r       = r_o_rgb[23:16];
    assign o_vga.g       = r_o_rgb[15:8];
    assign o_vga.b       = r_o_rgb[7:0];
    assign o_vga.hs      = r_o_hs;
    assign o_vga.vs      = r_o_vs;
    assign o_vga.sync_n  = r_o_sync_n;
    assign o_vga.blank_n = r_o_blank_n;

    assign hit_count   = r_hit_count;
    assign bbox_x0     = r_bx0;
    assign bbox_x1     = r_bx1;
    assign bbox_y0     = r_by0;
    assign bbox_y1     = r_by1;
    assign bbox_empty  = r_bbox_empty;
    assign stats_valid = r_stats_valid;
    assign frame_err   = r_frame_err;
    assign frame_done  = r_frame_done;
endmodule

// File: tb/tb_vga_bbox_overlay.sv
// Directed-frame bench for vga_bbox_overlay on a 10x10 active window.
// Each frame has two vsync lines, two back-porch lines, ten active lines and one front-porch line.
module tb_vga_bbox_overlay;
    localparam int W = 10;
    localparam int H = 10;

    logic        VGA_CLK = 1'b0;
    logic        reset_n;
    logic [7:0]  threshold;
    logic        overlay_en;
    logic [19:0] hit_count;
    logic [9:0]  bbox_x0, bbox_x1, bbox_y0, bbox_y1;
    logic        bbox_empty, stats_valid, frame_err, frame_done;

    vga_bbox_if vin();
    vga_bbox_if vout();

    vga_bbox_overlay #(.WIDTH(W), .HEIGHT(H), .CNT_W(20), .BOX_RGB(24'hFF0000)) dut (
        .VGA_CLK(VGA_CLK), .reset_n(reset_n), .i_vga(vin), .o_vga(vout),
        .threshold(threshold), .overlay_en(overlay_en), .hit_count(hit_count),
        .bbox_x0(bbox_x0), .bbox_x1(bbox_x1), .bbox_y0(bbox_y0), .bbox_y1(bbox_y1),
        .bbox_empty(bbox_empty), .stats_valid(stats_valid), .frame_err(frame_err),
        .frame_done(frame_done)
    );

    always #20 VGA_CLK = ~VGA_CLK;

    int n_chk = 0;
    int n_err = 0;
    int sync_bad = 0;
    int pix_bad, red_cnt, fd_cnt;
    int ex0, ex1, ey0, ey1;
    bit tgl = 1'b0;

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int mode, input int x, input int y);
        logic [7:0] r;
        r = 8'd0;
        if (mode == 1 && x == 3 && y == 7) r = 8'd200;
        if (mode == 2) r = 8'(x * 20);
        return {r, 16'h0};
    endfunction

    function automatic bit on_box(input int x, input int y);
        return ((x == ex0 || x == ex1) && y >= ey0 && y <= ey1) ||
               ((y == ey0 || y == ey1) && x >= ex0 && x <= ex1);
    endfunction

    // One pixel clock; outputs are sampled 1 time unit after the edge that registered these inputs.
    task automatic cyc(input logic [23:0] rgb, input logic hs, input logic vs,
                       input logic blank, input logic [23:0] exp);
        logic rst_edge;
        tgl = ~tgl;
        {vin.r, vin.g, vin.b} = rgb;
        vin.hs = hs; vin.vs = vs; vin.blank_n = blank; vin.sync_n = tgl;
        @(posedge VGA_CLK);
        rst_edge = reset_n;
        #1;
        if (rst_edge) begin
            if ({vout.hs, vout.vs, vout.sync_n, vout.blank_n} !== {hs, vs, tgl, blank}) sync_bad++;
            if ({vout.r, vout.g, vout.b} !== exp) pix_bad++;
            if ({vout.r, vout.g, vout.b} === 24'hFF0000) red_cnt++;
        end
        if (frame_done) fd_cnt++;
    endtask

    task automatic line(input logic vs, input bit act, input int y, input int npix,
                        input int mode, input bit ovl);
        logic [23:0] p;
        for (int x = 0; x < (act ? npix : W); x++) begin
            if (act) begin
                p = pix(mode, x, y);
                cyc(p, 1'b1, vs, 1'b1, (ovl && on_box(x, y)) ? 24'hFF0000 : p);
            end else begin
                cyc(24'h0, 1'b1, vs, 1'b0, 24'h0);
            end
        end
        for (int i = 0; i < 7; i++)
            cyc(24'h0, (i >= 2 && i < 5) ? 1'b0 : 1'b1, vs, 1'b0, 24'h0);
    endtask

    task automatic frame(input int mode, input bit ovl, input bit long_line, input int rst_line);
        pix_bad = 0; red_cnt = 0; fd_cnt = 0;
        for (int l = 0; l < 2; l++) line(1'b0, 1'b0, 0, 0, 0, 1'b0);
        for (int l = 0; l < 2; l++) line(1'b1, 1'b0, 0, 0, 0, 1'b0);
        for (int y = 0; y < H; y++) begin
            if (y == rst_line) reset_n = 1'b0;
            line(1'b1, 1'b1, y, (long_line && y == 4) ? W + 1 : W, mode, ovl);
            reset_n = 1'b1;
        end
        line(1'b1, 1'b0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; threshold = 8'd1; overlay_en = 1'b0;
        ex0 = 0; ex1 = 0; ey0 = 0; ey1 = 0;
        pix_bad = 0; red_cnt = 0; fd_cnt = 0;
        for (int i = 0; i < 6; i++) cyc(24'h0, 1'b1, 1'b1, 1'b0, 24'h0);

        chk("rst_vga_ctl", {vout.hs, vout.vs, vout.sync_n, vout.blank_n}, 40'b1100);
        chk("rst_vga_rgb", {vout.r, vout.g, vout.b}, 40'h0);
        chk("rst_hit_count", hit_count, 40'h0);
        chk("rst_bbox", {bbox_x0, bbox_x1, bbox_y0, bbox_y1}, 40'h0);
        chk("rst_flags", {bbox_empty, stats_valid, frame_err, frame_done}, 40'b1000);
        reset_n = 1'b1;

        // F1: all zero, threshold 1; its vsync only syncs up.
        frame(0, 1'b0, 1'b0, -1);
        chk("f1_no_frame_done", fd_cnt, 40'd0);
        chk("f1_stats_valid", stats_valid, 40'd0);

        // F2: single bright pixel; latches F1 statistics.
        threshold = 8'd128;
        frame(1, 1'b0, 1'b0, -1);
        chk("f2_frame_done", fd_cnt, 40'd1);
        chk("f2_stats", {stats_valid, bbox_empty, frame_err}, 40'b110);
        chk("f2_hit_count", hit_count, 40'd0);
        chk("f2_bbox_zero", {bbox_x0, bbox_x1, bbox_y0, bbox_y1}, 40'h0);
        chk("f2_pix", pix_bad, 40'd0);

        // F3: box from F2 is the single pixel (3,7).
        overlay_en = 1'b1; ex0 = 3; ex1 = 3; ey0 = 7; ey1 = 7;
        frame(1, 1'b1, 1'b0, -1);
        chk("f3_hit_count", hit_count, 40'd1);
        chk("f3_bbox", {bbox_x0, bbox_x1, bbox_y0, bbox_y1}, {10'd3, 10'd3, 10'd7, 10'd7});
        chk("f3_empty", bbox_empty, 40'd0);
        chk("f3_pix", pix_bad, 40'd0);
        chk("f3_red_cnt", red_cnt, 40'd1);

        // F4: ramp R = x*20 at threshold 100, still showing the single-pixel box.
        threshold = 8'd100;
        frame(2, 1'b1, 1'b0, -1);
        chk("f4_pix", pix_bad, 40'd0);

        // F5: ramp again, now showing the ramp box x 5..9, y 0..9.
        ex0 = 5; ex1 = 9; ey0 = 0; ey1 = 9;
        frame(2, 1'b1, 1'b0, -1);
        chk("f5_hit_count", hit_count, 40'd50);
        chk("f5_bbox", {bbox_x0, bbox_x1, bbox_y0, bbox_y1}, {10'd5, 10'd9, 10'd0, 10'd9});
        chk("f5_pix", pix_bad, 40'd0);
        chk("f5_red_cnt", red_cnt, 40'd26);

        // F6: one line with 11 active pixels; F7 reports it, F8 is clean again.
        overlay_en = 1'b0; threshold = 8'd1;
        frame(0, 1'b0, 1'b1, -1);
        chk("f6_err_before_latch", frame_err, 40'd0);
        frame(0, 1'b0, 1'b0, -1);
        chk("f7_frame_err", frame_err, 40'd1);
        chk("f7_empty_hits", {bbox_empty, 20'(hit_count)}, {1'b1, 20'd0});
        frame(0, 1'b0, 1'b0, -1);
        chk("f8_frame_err", frame_err, 40'd0);

        // F9: reset in the middle; F10 only resyncs, F11 latches again.
        frame(0, 1'b0, 1'b0, 3);
        chk("f9_valid_after_rst", stats_valid, 40'd0);
        chk("f9_empty_after_rst", bbox_empty, 40'd1);
        frame(0, 1'b0, 1'b0, -1);
        chk("f10_no_frame_done", fd_cnt, 40'd0);
        chk("f10_stats_valid", stats_valid, 40'd0);
        frame(1, 1'b0, 1'b0, -1);
        chk("f11_frame_done", fd_cnt, 40'd1);
        chk("f11_stats", {stats_valid, bbox_empty, frame_err}, 40'b110);
        chk("f11_pix", pix_bad, 40'd0);

        chk("sync_delay", sync_bad, 40'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
